// File: rtl/door_pkg.sv
// Shared door types: state and motor-command encodings plus a width helper.
// Used by door_plant_model (optional DOOR_FAULT_EN build) and by the controller side.
package door_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RISING  = 2'd1;
    localparam logic [1:0] FALLING = 2'd2;
    localparam logic [1:0] FAULT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_RISING  = RISING,
        ST_FALLING = FALLING,
        ST_FAULT   = FAULT
    } door_state_e;

    // Motor command as seen on the wire, packed {UP_M, DN_M}.
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_DN   = 2'b01;
    localparam logic [1:0] CMD_UP   = 2'b10;
    localparam logic [1:0] CMD_BOTH = 2'b11;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic door_state_e decode_motor(input logic up_m, input logic dn_m);
        case ({up_m, dn_m})
            CMD_UP:  return ST_RISING;
            CMD_DN:  return ST_FALLING;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/door_plant_model_if.sv
// Motor/limit link between the door controller (master) and the door plant (slave).
// The fault signal exists only when DOOR_FAULT_EN is defined.
interface door_plant_model_if #(
    parameter int POS_W = 5
);
    logic             UP_M;
    logic             DN_M;
    logic             UP_Max;
    logic             DN_Max;
    logic [POS_W-1:0] pos;
    logic             moving;
`ifdef DOOR_FAULT_EN
    logic             fault;

    modport master (output UP_M, DN_M, input UP_Max, DN_Max, pos, moving, fault);
    modport slave  (input UP_M, DN_M, output UP_Max, DN_Max, pos, moving, fault);
`else
    modport master (output UP_M, DN_M, input UP_Max, DN_Max, pos, moving);
    modport slave  (input UP_M, DN_M, output UP_Max, DN_Max, pos, moving);
`endif
endinterface

// File: rtl/door_step_div.sv
// STEP_DIV prescaler: turns sustained motor drive into one-cycle position step pulses.
// clr restarts the interval on the same edge; step qualifies the edge on which the count wraps.
module door_step_div
    import door_pkg::*;
#(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int CNT_W = clog2w(STEP_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] base;

    assign base = clr ? '0 : cnt;
    assign step = en && (base == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || !en || step) begin
            cnt <= '0;
        end else begin
            cnt <= base + 1'b1;
        end
    end

endmodule

// File: rtl/door_plant_model.sv
// Garage door plant: integrates position from UP_M/DN_M and returns registered limit switches.
// Define DOOR_FAULT_EN to add the sticky fault output and FAULT state (both-motor and stall).
module door_plant_model
    import door_pkg::*;
#(
    parameter int TRAVEL_STEPS = 16,
    parameter int STEP_DIV     = 4,
    parameter int INIT_POS     = 0,
    parameter int STALL_CYC    = 8
) (
    input  logic clk,
    input  logic rst,
    door_plant_model_if.slave bus
);

    localparam int POS_W = clog2w(TRAVEL_STEPS + 1);
    localparam logic [POS_W-1:0] TOP_POS    = POS_W'(TRAVEL_STEPS);
    localparam logic [POS_W-1:0] INIT_POS_V = POS_W'(INIT_POS);

    if (TRAVEL_STEPS < 1 || STEP_DIV < 1 || INIT_POS < 0 || INIT_POS > TRAVEL_STEPS ||
        STALL_CYC < 1) begin : g_bad_cfg
        $error("door_plant_model: illegal parameter set");
    end

    door_state_e      state;
    door_state_e      cmd;
    door_state_e      state_nxt;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_nxt;
    logic             up_max_q;
    logic             dn_max_q;
    logic             moving_q;
    logic             saturated;
    logic             frozen;
    logic             fault_hit;
    logic             step;
    logic             div_en;
    logic             div_clr;

    assign cmd       = decode_motor(bus.UP_M, bus.DN_M);
    assign saturated = (cmd == ST_RISING && up_max_q) || (cmd == ST_FALLING && dn_max_q);

`ifdef DOOR_FAULT_EN
    localparam int STALL_W = clog2w(STALL_CYC);

    logic               both_seen;
    logic [STALL_W-1:0] stall_cnt;
    logic               fault_q;

    assign frozen    = (state == ST_FAULT);
    assign fault_hit = (bus.UP_M && bus.DN_M && both_seen) ||
                       (saturated && stall_cnt == STALL_W'(STALL_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            both_seen <= 1'b0;
            stall_cnt <= '0;
            fault_q   <= 1'b0;
        end else begin
            both_seen <= bus.UP_M && bus.DN_M;
            stall_cnt <= saturated ? stall_cnt + 1'b1 : '0;
            if (fault_hit) fault_q <= 1'b1;
        end
    end

    assign bus.fault = fault_q;
`else
    assign frozen    = 1'b0;
    assign fault_hit = 1'b0;
`endif

    // A direction change (including leaving IDLE) restarts the full step interval.
    assign div_en  = !frozen && !saturated && (cmd == ST_RISING || cmd == ST_FALLING);
    assign div_clr = (cmd != state);

    door_step_div #(
        .STEP_DIV (STEP_DIV)
    ) u_step_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (div_clr),
        .step (step)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = cmd;
        pos_nxt   = pos_q;
        if (frozen || fault_hit) begin
            state_nxt = ST_FAULT;
        end else if (step) begin
            pos_nxt = (cmd == ST_RISING) ? pos_q + 1'b1 : pos_q - 1'b1;
        end
    end

    // Limits come from next-pos so they switch on the same edge as pos.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pos_q    <= INIT_POS_V;
            up_max_q <= (INIT_POS == TRAVEL_STEPS);
            dn_max_q <= (INIT_POS == 0);
            moving_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            pos_q    <= pos_nxt;
            up_max_q <= (pos_nxt == TOP_POS);
            dn_max_q <= (pos_nxt == '0);
            moving_q <= (state_nxt == ST_RISING) || (state_nxt == ST_FALLING);
        end
    end

    assign bus.pos    = pos_q;
    assign bus.UP_Max = up_max_q;
    assign bus.DN_Max = dn_max_q;
    assign bus.moving = moving_q;

endmodule

// File: tb/tb_door_plant_model.sv
// Directed plus random bench for door_plant_model against a travel-rule reference model.
// Follows DOOR_FAULT_EN so the same file covers both builds.
module tb_door_plant_model;
    import door_pkg::*;

    localparam int TRAVEL_STEPS = 16;
    localparam int STEP_DIV     = 4;
    localparam int INIT_POS     = 0;
    localparam int STALL_CYC    = 8;
    localparam int POS_W        = clog2w(TRAVEL_STEPS + 1);

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    door_plant_model_if #(.POS_W(POS_W)) bus ();

    door_plant_model #(
        .TRAVEL_STEPS (TRAVEL_STEPS),
        .STEP_DIV     (STEP_DIV),
        .INIT_POS     (INIT_POS),
        .STALL_CYC    (STALL_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: position advances once per STEP_DIV consecutive edges of one direction.
    int m_pos;
    int m_dir_prev;
    int m_held;
    int m_moving;
    int m_fault;
    int m_both_run;
    int m_stall_run;

    task automatic model_edge(input logic r, input logic up, input logic dn);
        int  dir;
        bit  at_lim;
        if (r) begin
            m_pos = INIT_POS; m_dir_prev = 0; m_held = 0; m_moving = 0;
            m_fault = 0; m_both_run = 0; m_stall_run = 0;
            return;
        end
        if (m_fault != 0) begin
            m_moving = 0;
            return;
        end
        dir = (up && !dn) ? 1 : (dn && !up) ? -1 : 0;
        m_both_run  = (up && dn) ? m_both_run + 1 : 0;
        at_lim      = (dir == 1 && m_pos == TRAVEL_STEPS) || (dir == -1 && m_pos == 0);
        m_stall_run = at_lim ? m_stall_run + 1 : 0;
`ifdef DOOR_FAULT_EN
        if (m_both_run >= 2 || m_stall_run >= STALL_CYC) begin
            m_fault = 1;
            m_moving = 0;
            return;
        end
`endif
        if (dir == 0 || at_lim) begin
            m_held = 0;
        end else begin
            m_held = ((dir == m_dir_prev) ? m_held : 0) + 1;
            if (m_held % STEP_DIV == 0) m_pos = m_pos + dir;
        end
        m_dir_prev = dir;
        m_moving   = (dir != 0) ? 1 : 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge: advance the model with the inputs that were present, then compare.
    task automatic tick(input string phase);
        @(posedge clk);
        model_edge(rst, bus.UP_M, bus.DN_M);
        #1;
        check({phase, ".pos"},    32'(bus.pos),    32'(m_pos));
        check({phase, ".UP_Max"}, 32'(bus.UP_Max), 32'(m_pos == TRAVEL_STEPS));
        check({phase, ".DN_Max"}, 32'(bus.DN_Max), 32'(m_pos == 0));
        check({phase, ".moving"}, 32'(bus.moving), 32'(m_moving));
`ifdef DOOR_FAULT_EN
        check({phase, ".fault"},  32'(bus.fault),  32'(m_fault));
`endif
    endtask

    task automatic drive(input logic up, input logic dn, input int n, input string phase);
        bus.UP_M = up;
        bus.DN_M = dn;
        for (int i = 0; i < n; i++) tick(phase);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick("reset");
        rst = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        bus.UP_M = 1'b0;
        bus.DN_M = 1'b0;

        // Reset state, then full rise from closed, holding just short of a stall.
        do_reset();
        drive(1'b1, 1'b0, 3, "rise_pre");
        drive(1'b1, 1'b0, 1, "rise_first_step");
        check("first_step_pos", 32'(bus.pos), 32'd1);
        drive(1'b1, 1'b0, 60, "rise");
        check("open_pos", 32'(bus.pos), 32'(TRAVEL_STEPS));
        check("open_limit", 32'(bus.UP_Max), 32'd1);
        drive(1'b1, 1'b0, 2, "rise_hold");

        // Partial close from fully open, then motors off.
        drive(1'b0, 1'b1, 20, "fall20");
        check("fall20_pos", 32'(bus.pos), 32'(TRAVEL_STEPS - 5));
        drive(1'b0, 1'b0, 2, "stop");

        // Reversal mid-interval restarts the full step interval.
        do_reset();
        drive(1'b1, 1'b0, 6, "rev_up");
        drive(1'b0, 1'b1, 3, "rev_dn_wait");
        check("rev_hold_pos", 32'(bus.pos), 32'd1);
        drive(1'b0, 1'b1, 2, "rev_dn_close");

        // Both motors mid-travel.
        do_reset();
        drive(1'b1, 1'b0, 30, "mid_up");
        drive(1'b1, 1'b1, 10, "both");
        drive(1'b0, 1'b0, 3, "both_release");

        // Driving into the open limit long enough to stall.
        do_reset();
        drive(1'b1, 1'b0, 75, "stall");
        drive(1'b0, 1'b0, 2, "stall_release");

        // Reset mid-rise with the motor still on.
        do_reset();
        drive(1'b1, 1'b0, 28, "pre_rst_rise");
        check("pre_rst_pos", 32'(bus.pos), 32'd7);
        do_reset();
        check("post_rst_pos", 32'(bus.pos), 32'(INIT_POS));
        drive(1'b1, 1'b0, 5, "post_rst_rise");

        // Random motor segments with occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            int p;
            int len;
            p   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 25));
            if ($urandom_range(0, 19) == 0) do_reset();
            if (p < 4)      drive(1'b1, 1'b0, len, "rnd_up");
            else if (p < 7) drive(1'b0, 1'b1, len, "rnd_dn");
            else if (p < 9) drive(1'b0, 1'b0, len, "rnd_idle");
            else            drive(1'b1, 1'b1, len, "rnd_both");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
